// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, requester-id and memory-direction encodings for the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
    localparam logic REQ_I     = 1'b0;
    localparam logic REQ_D     = 1'b1;
    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory-side bus of the memory arbiter
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req_valid;
    logic [AW-1:0] i_req_addr;
    logic          i_req_ready;
    logic          i_rsp_valid;
    logic [DW-1:0] i_rsp_data;
    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rw;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input  i_req_valid, i_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata, mem_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
               mem_addr, mem_wdata, mem_rw
    );
    modport master (
        output i_req_valid, i_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata, mem_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
               mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker (bit 0 = fetch, bit 1 = data)
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);
    // a lone requester always wins; a tie goes to the side that did not win last time
    always_comb begin
        o_grant = (&i_valid) ? ((i_last_grant == REQ_D) ? 2'b01 : 2'b10) : i_valid;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 1-cycle-latency memory between instruction fetch and load/store
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         resetn,
    mem_arbiter_if.slave bus
);
    state_t        r_state;
    logic          r_last_grant;
    logic          r_id;
    logic          r_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_rw;
    logic [1:0]    w_grant;
    logic [1:0]    w_ready;
    logic          w_hs;
    logic          w_gnt_d;
    logic          w_resp;
    logic          w_rsp_i;
    logic          w_rsp_d;

    rr_arb2 u_rr (
        .i_valid      ({bus.d_req_valid, bus.i_req_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // accept only in IDLE and never while reset is held; responses only in RESP
    always_comb begin
        w_ready = (resetn && r_state == IDLE) ? w_grant : 2'b00;
        w_hs    = |w_ready;
        w_gnt_d = w_ready[1];
        w_resp  = resetn && r_state == RESP;
        w_rsp_i = w_resp && r_id == REQ_I;
        w_rsp_d = w_resp && r_id == REQ_D;
    end

    // fixed three-step walk: accept, access memory, respond
    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= (r_state == IDLE) ? (w_hs ? ACCESS : IDLE) : (r_state == ACCESS) ? RESP : IDLE;
    end

    // latch the winner's request; memory lines stay a harmless read except during a store's ACCESS
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant <= REQ_D;
            r_id         <= REQ_I;
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_rw     <= MEM_READ;
        end else if (w_hs) begin
            r_last_grant <= w_gnt_d;
            r_id         <= w_gnt_d;
            r_we         <= w_gnt_d & bus.d_req_we;
            r_mem_addr   <= w_gnt_d ? bus.d_req_addr : bus.i_req_addr;
            r_mem_wdata  <= w_gnt_d ? bus.d_req_wdata : '0;
            r_mem_rw     <= (w_gnt_d && bus.d_req_we) ? MEM_WRITE : MEM_READ;
        end else begin
            r_mem_rw     <= MEM_READ;
        end
    end

    assign bus.i_req_ready = w_ready[0];
    assign bus.d_req_ready = w_ready[1];
    assign bus.i_rsp_valid = w_rsp_i;
    assign bus.d_rsp_valid = w_rsp_d;
    assign bus.i_rsp_data  = w_rsp_i ? bus.mem_rdata : '0;
    assign bus.d_rsp_data  = (w_rsp_d && !r_we) ? bus.mem_rdata : '0;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_rw      = r_mem_rw;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized check of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    function automatic logic [31:0] init_word(input int k);
        return (k == 2) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(k) * 32'h0101_0011;
    endfunction

    // word memory seen by the arbiter: registered read, write when mem_rw is low
    logic [31:0] tb_mem [16];
    always @(posedge clk) begin
        if (mem_init)
            for (int k = 0; k < 16; k++) tb_mem[k] <= init_word(k);
        else if (bus.mem_rw == 1'b0)
            tb_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        bus.mem_rdata <= tb_mem[bus.mem_addr[5:2]];
    end

    // reference model state: expected memory image and the transaction in flight
    logic [31:0] ref_mem [16];
    int          busy = 0;
    logic        last = 1'b1;
    logic        cur_id = 1'b0;
    logic        cur_we = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wd = '0;
    logic [31:0] exp_maddr = '0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic        hold_i = 1'b0;
    logic        hold_d = 1'b0;
    logic        rnd = 1'b0;
    logic        d_loads_only = 1'b0;
    int          rw_low = 0;
    int          i_rsp_cnt = 0;
    logic [31:0] last_i_data = '0;
    logic [31:0] last_d_data = '0;
    logic        gq [$];
    logic [3:0]  pat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic gen_i();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'($urandom_range(0, 63));
    endtask

    task automatic gen_d();
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = d_loads_only ? 1'b0 : 1'($urandom_range(0, 1));
        bus.d_req_addr  = 32'($urandom_range(0, 63));
        bus.d_req_wdata = $urandom;
    endtask

    // one clock: check outputs mid-cycle, advance the model at the edge, drive requesters at negedge
    task automatic step();
        logic ei, ed, hi, hd, rvi, rvd;
        logic [31:0] rd;
        #1;
        ei  = resetn && busy == 0 && bus.i_req_valid && (!bus.d_req_valid || last);
        ed  = resetn && busy == 0 && bus.d_req_valid && (!bus.i_req_valid || !last);
        rvi = resetn && busy == 1 && !cur_id;
        rvd = resetn && busy == 1 && cur_id;
        rd  = (busy == 1 && !cur_we) ? ref_mem[cur_addr[5:2]] : 32'h0;
        hi  = bus.i_req_ready;
        hd  = bus.d_req_ready;
        check("i_req_ready", hi, ei);
        check("d_req_ready", hd, ed);
        check("i_rsp_valid", bus.i_rsp_valid, rvi);
        check("i_rsp_data", bus.i_rsp_data, rvi ? rd : 32'h0);
        check("d_rsp_valid", bus.d_rsp_valid, rvd);
        check("d_rsp_data", bus.d_rsp_data, rvd ? rd : 32'h0);
        check("mem_rw", bus.mem_rw, !(busy == 2 && cur_we));
        check("mem_addr", bus.mem_addr, exp_maddr);
        if (busy == 2 && cur_we) check("mem_wdata", bus.mem_wdata, cur_wd);
        if (bus.mem_rw == 1'b0) rw_low++;
        if (bus.i_rsp_valid) begin i_rsp_cnt++; last_i_data = bus.i_rsp_data; end
        if (bus.d_rsp_valid) last_d_data = bus.d_rsp_data;
        if (hi || hd) gq.push_back(hd);
        @(posedge clk);
        if (busy == 2 && cur_we) ref_mem[cur_addr[5:2]] = cur_wd;
        if (!resetn) begin
            busy = 0; last = 1'b1; exp_maddr = '0;
        end else if (ei || ed) begin
            cur_id = ed; cur_we = ed && bus.d_req_we;
            cur_addr = ed ? bus.d_req_addr : bus.i_req_addr;
            cur_wd = bus.d_req_wdata; last = ed; exp_maddr = cur_addr; busy = 2;
        end else if (busy > 0) begin
            busy--;
        end
        @(negedge clk);
        if (hi) begin if (hold_i) gen_i(); else bus.i_req_valid = 1'b0; end
        if (hd) begin if (hold_d) gen_d(); else bus.d_req_valid = 1'b0; end
        if (rnd && !bus.i_req_valid && $urandom_range(0, 2) == 0) gen_i();
        if (rnd && !bus.d_req_valid && $urandom_range(0, 2) == 0) gen_d();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
        bus.i_req_valid = 1'b0; bus.i_req_addr = '0;
        bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_req_addr = '0; bus.d_req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        step();
        resetn = 1'b1;
        // single fetch of the preloaded word
        bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h8;
        repeat (4) step();
        check("fetch_rsp_count", i_rsp_cnt, 1);
        check("fetch_data", last_i_data, 32'hDEADBEEF);
        // store then load the same word
        rw_low = 0; last_d_data = 32'hFFFF_FFFF;
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 32'h10; bus.d_req_wdata = 32'h12345678;
        repeat (4) step();
        check("store_rw_low_cycles", rw_low, 1);
        check("store_ack_data", last_d_data, 32'h0);
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h10;
        repeat (4) step();
        check("load_after_store", last_d_data, 32'h12345678);
        // idle period
        rw_low = 0;
        repeat (10) step();
        check("idle_rw_low_cycles", rw_low, 0);
        // both requesters held from reset: alternate I, D, I, D
        resetn = 1'b0; hold_i = 1'b1; hold_d = 1'b1; gen_i(); gen_d();
        step();
        resetn = 1'b1; gq.delete();
        repeat (12) step();
        pat = (gq.size() >= 4) ? {gq[0], gq[1], gq[2], gq[3]} : 4'hF;
        check("tie_grant_order", pat, 4'b0101);
        hold_i = 1'b0; hold_d = 1'b0;
        repeat (8) step();
        // reset during ACCESS of a fetch drops the response
        i_rsp_cnt = 0;
        bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h8;
        step();
        resetn = 1'b0;
        repeat (2) step();
        check("reset_drops_rsp", i_rsp_cnt, 0);
        gq.delete(); gen_i(); gen_d(); resetn = 1'b1;
        repeat (7) step();
        check("first_tie_after_reset", (gq.size() > 0) ? gq[0] : 1'b1, 1'b0);
        // back-to-back loads with the data valid held
        d_loads_only = 1'b1; hold_d = 1'b1; gq.delete(); gen_d();
        repeat (12) step();
        check("b2b_load_count", gq.size(), 4);
        hold_d = 1'b0;
        repeat (3) step();
        d_loads_only = 1'b0;
        // random traffic with occasional reset pulses
        rnd = 1'b1;
        for (int c = 0; c < 400; c++) begin
            resetn = ($urandom_range(0, 59) != 0);
            step();
        end
        resetn = 1'b1; rnd = 1'b0;
        repeat (8) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port, 1-cycle-latency word memory between the CPU instruction-fetch port and a new CPU load/store port. It sits between `cpu` and `memory` inside `soc`, replacing the direct `mem_addr`/`mem_rdata` wiring. It accepts one request at a time through a valid/ready handshake, drives the memory's address, write-data and `mem_rw` lines, and returns read data with a one-cycle response pulse. Ties go round-robin.

## Interface
Parameters:
- `AW`, default 32: byte-address width.
- `DW`, default 32: data width.

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `i_req_valid`, in, 1: instruction-fetch read request.
- `i_req_addr`, in, AW: fetch byte address.
- `i_req_ready`, out, 1: fetch request accepted this cycle.
- `i_rsp_valid`, out, 1: one-cycle pulse; fetch data valid.
- `i_rsp_data`, out, DW: fetch read data.
- `d_req_valid`, in, 1: load/store request.
- `d_req_we`, in, 1: 1 = store, 0 = load.
- `d_req_addr`, in, AW: data byte address.
- `d_req_wdata`, in, DW: store data.
- `d_req_ready`, out, 1: data request accepted this cycle.
- `d_rsp_valid`, out, 1: one-cycle pulse; load data valid or store complete.
- `d_rsp_data`, out, DW: load data; 0 on a store acknowledgement.
- `mem_addr`, out, AW: byte address to memory. The memory uses bits [AW-1:2].
- `mem_wdata`, out, DW: write data to memory.
- `mem_rw`, out, 1: 1 = read, 0 = write.
- `mem_rdata`, in, DW: registered memory read data, valid the cycle after the address.

## Operation
- The state machine has three states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS on an accepted request.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- `*_req_ready` can be high only in IDLE. It is combinational from the valids and the round-robin pointer. At most one ready is high per cycle.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted last.
  - `last_grant` resets to D, so I wins the first tie after reset.
  - `last_grant` updates only on a handshake.
- On a handshake, capture the following into registers:
  - requester id;
  - addr;
  - we (forced to 0 for I);
  - wdata.
- `mem_addr`, `mem_wdata` and `mem_rw` are registered.
  - They load on the handshake edge and are presented during ACCESS.
  - `mem_rw` = 0 only during ACCESS of a store. Otherwise it is 1 (a harmless read).
  - `mem_addr` holds its last value outside ACCESS.
- In RESP, only the captured requester's `*_rsp_valid` = 1.
  - Read: `*_rsp_data` = `mem_rdata`, passed through combinationally.
  - Store: `d_rsp_data` = 0.
  - Outside RESP: both rsp_valid = 0 and both rsp_data = 0.
- Requesters hold valid and request fields stable until ready. A valid must not depend on ready.
- Address bits [1:0] pass through unchanged. No alignment check is made.

## Timing
- Fetch handshake at the end of cycle N:
  - Cycle N+1: ACCESS, memory sees the address.
  - Cycle N+2: RESP, data delivered.
  - Cycle N+3: IDLE, next accept possible.
- Throughput is one transaction per 3 cycles. Load-use latency is 2 cycles after the handshake.
- Reset values:
  - state IDLE;
  - `mem_addr` 0, `mem_wdata` 0, `mem_rw` 1;
  - all ready, rsp_valid and rsp_data outputs 0;
  - `last_grant` D.
- Reset mid-transaction: the transaction is dropped and no rsp_valid is issued.
  - A store already in ACCESS when resetn goes low still commits at that edge, because the memory is not reset.
- A new valid arriving during ACCESS or RESP waits until IDLE. No request is lost, since requesters hold their valids.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - requester id constants REQ_I = 0, REQ_D = 1;
  - the `mem_rw` encodings MEM_READ = 1, MEM_WRITE = 0.
- Sub-module `rr_arb2`: a 2-way round-robin picker.
  - Inputs: two valids, `last_grant`.
  - Output: one-hot grant.
  - It is purely combinational. The pointer register stays in `mem_arbiter`.

## Test plan
- Memory word 2 preloaded with 0xDEADBEEF; single fetch to 0x8 → `i_req_ready` in cycle 0, `mem_addr` = 0x8 with `mem_rw` = 1 in cycle 1, `i_rsp_valid` = 1 with 0xDEADBEEF in cycle 2.
- Store 0x12345678 to 0x10, then load from 0x10 → `mem_rw` = 0 for exactly one cycle; store ack has `d_rsp_data` = 0; load returns 0x12345678.
- Both valids held high continuously from reset → grants I, D, I, D; handshakes 3 cycles apart; each response goes only to its granted requester.
- Assert resetn low during ACCESS of a fetch → no `i_rsp_valid`; all outputs at reset values; first grant after reset on a tie is I.
- No requests for 10 cycles → `mem_rw` stays 1; ready and rsp_valid stay 0.
- Back-to-back data loads with `d_req_valid` held → readys 3 cycles apart; data correct per address.
